// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle on a shared adder.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIN, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nxt;
  logic [2:0]        op;
  logic [XLEN-1:0]   hi, lo, b_q;
  logic [CNT_W-1:0]  cnt;
  logic              sign_a, sign_b;

  logic              is_div, a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, overflow, special;
  logic [XLEN-1:0]   special_val;
  logic [XLEN:0]     add_a, add_b;
  logic              add_cin;
  logic [XLEN+1:0]   add_sum;
  logic              carry;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin_val;

  assign is_div   = op[2];
  assign a_signed = (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
  assign b_signed = (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);

  // During PREP, lo and b_q still hold the raw operands latched in IDLE
  assign neg_a = a_signed & lo[XLEN-1];
  assign neg_b = b_signed & b_q[XLEN-1];
  assign a_mag = neg_a ? (~lo + 1'b1) : lo;
  assign b_mag = neg_b ? (~b_q + 1'b1) : b_q;

  assign div_zero = is_div & (b_q == '0);
  assign overflow = ((op == OP_DIV) | (op == OP_REM)) & (lo == MIN_NEG) & (b_q == '1);
  assign special  = div_zero | overflow;

  always_comb begin
    special_val = '0;
    if (div_zero)      special_val = op[1] ? lo : '1;
    else if (overflow) special_val = op[1] ? '0 : MIN_NEG;
  end

  // Shared adder: hi accumulates the product, or holds the partial remainder
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (is_div) begin
      add_a   = {hi, lo[XLEN-1]};
      add_b   = ~{1'b0, b_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, hi};
      add_b   = lo[0] ? {1'b0, b_q} : '0;
    end
  end

  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, add_cin};
  assign carry   = add_sum[XLEN+1];

  assign prod   = {hi, lo};
  assign prod_s = (sign_a ^ sign_b) ? (~prod + 1'b1) : prod;
  assign quo_s  = (sign_a ^ sign_b) ? (~lo + 1'b1) : lo;
  assign rem_s  = sign_a ? (~hi + 1'b1) : hi;

  always_comb begin
    fin_val = '0;
    case (op)
      OP_MUL:                        fin_val = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin_val = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fin_val = quo_s;
      OP_REM, OP_REMU:               fin_val = rem_s;
      default:                       fin_val = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          state_nxt = PREP;
          stall     = 1'b1;
        end
      end
      PREP: begin
        stall     = 1'b1;
        state_nxt = special ? DONE : CALC;
      end
      CALC: begin
        stall = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = FIN;
      end
      FIN: begin
        stall     = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= '0;
      op     <= '0;
      hi     <= '0;
      lo     <= '0;
      b_q    <= '0;
      cnt    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op  <= funct3;
            lo  <= src_a;
            b_q <= src_b;
          end
        end
        PREP: begin
          sign_a <= neg_a;
          sign_b <= neg_b;
          lo     <= a_mag;
          b_q    <= b_mag;
          hi     <= '0;
          cnt    <= CNT_W'(XLEN);
          if (special && !flush) result <= special_val;
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            hi <= carry ? add_sum[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
            lo <= {lo[XLEN-2:0], carry};
          end else begin
            hi <= add_sum[XLEN:1];
            lo <= {add_sum[0], lo[XLEN-1:1]};
          end
        end
        FIN: begin
          if (!flush) result <= fin_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer in the EX stage, beside the single-cycle ALU.
- Accepts one M-extension op, stalls the pipeline while it runs, then presents the result for one cycle.
- Runs one shift-add or shift-subtract step per cycle on a shared XLEN+1-bit adder.
- Decoder raises start when opcode is OP and funct7 = 0000001; funct3 selects the operation.

Parameters:
- XLEN, 32, operand/result width; also the iteration count.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a  input  XLEN  rs1 operand (multiplicand / dividend).
- src_b  input  XLEN  rs2 operand (multiplier / divisor).
- flush  input  1  abort the current op (branch mispredict / trap).
- stall  output  1  combinational; holds IF/ID/EX.
- done  output  1  registered; one-cycle pulse, result valid.
- result  output  XLEN  registered; valid while done = 1.

Behaviour:
- Reset (rst_n = 0 at a clock edge): state = IDLE, done = 0, result = 0, counter = 0, all internal registers = 0. Reset mid-operation discards the op and produces no done.
- States: IDLE, PREP, CALC, FIN, DONE.
- IDLE: if start & ~flush, latch funct3, src_a, src_b and go to PREP. Otherwise stay.
- PREP:
  - Record operand signs: signed ops are MULH, MULHSU (a only), DIV, REM.
  - Replace signed negative operands with their two's-complement magnitude.
  - Load counter = XLEN and clear the accumulator.
  - Special cases, which set result here and go straight to DONE:
    - Divisor = 0: DIV/DIVU give all ones; REM/REMU give src_a.
    - Signed overflow (DIV/REM with src_a = 0x80000000, src_b = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Otherwise go to CALC.
- CALC: one step per cycle, counter decrements, go to FIN when counter reaches 1.
  - Multiply: unsigned shift-add over magnitudes into a 2*XLEN product.
  - Divide: restoring shift-subtract over magnitudes, producing quotient and remainder.
- FIN:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ (DIV only).
  - Give the remainder the sign of the dividend (REM only).
  - Select the output: MUL takes product[XLEN-1:0]; MULH, MULHSU and MULHU take product[2*XLEN-1:XLEN].
  - Register result, go to DONE.
- DONE: done = 1 for exactly this cycle, result held, return to IDLE. start is ignored in DONE; the pipeline advances this cycle.
- stall = (state == IDLE & start & ~flush) | state ∈ {PREP, CALC, FIN}. stall = 0 in DONE.
- Latency, with start accepted at cycle T:
  - Normal op: done at T+XLEN+3 (T+35 for XLEN = 32).
  - Special case: done at T+2.
- Back-to-back ops: a new start is accepted in the IDLE cycle right after DONE, so the minimum spacing between accepted starts is XLEN+4 cycles.
- flush: in any state, go to IDLE next cycle; done stays 0 and result keeps its old value. flush beats start in the same cycle. A flush in the DONE cycle does not cancel that cycle's done.
- start held high in non-IDLE states has no effect, and operands are not re-sampled.
- All arithmetic is modulo 2^XLEN on the output. Intermediate adder is XLEN+1 bits, so there is no carry loss.

Test Plan:
- MUL src_a = 7, src_b = 0xFFFFFFFD (-3) -> done at T+35, result 0xFFFFFFEB; stall high T..T+34, low at T+35.
- MULH / MULHSU / MULHU with a = 0x80000000, b = 0xFFFFFFFF -> MULH 0x00000000; MULHSU 0x80000000; MULHU 0x7FFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; all with done at T+35.
- Divide by zero:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; both with done at T+2.
  - Overflow DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, done at T+2.
- flush at T+10 of a DIVU -> IDLE at T+11, no done, result unchanged. start together with flush in IDLE -> not accepted.
- rst_n low at T+20 of a MUL -> result 0, done 0, stall 0. A new MUL 3*4 started two cycles after reset release -> result 12.
